// File: rtl/zone_arbiter_if.sv
// zone_arbiter_if: request/valve bundle between the zone controllers and the pump arbiter.
interface zone_arbiter_if #(parameter int NZONES = 4);
    logic [NZONES-1:0] water_req, zone_en, valve_en;
    logic stop, pump_on, busy, timeout;
    logic [$clog2(NZONES)-1:0] grant_id;
    modport master (output water_req, zone_en, stop, input valve_en, pump_on, grant_id, busy, timeout);
    modport slave (input water_req, zone_en, stop, output valve_en, pump_on, grant_id, busy, timeout);
endinterface

// File: rtl/zone_arbiter.sv
// zone_arbiter: round-robin arbiter granting one irrigation zone at a time the shared pump,
// with a per-grant on-time limit and a pressure-recovery gap between grants.
module zone_arbiter #(
    parameter int NZONES = 4,
    parameter logic [7:0] MAX_ON = 8'd200,
    parameter logic [7:0] GAP = 8'd4
) (
    input logic clk,
    input logic rst,
    zone_arbiter_if.slave bus
);
    localparam logic [1:0] IDLE = 2'd0, GRANT = 2'd1, COOLDOWN = 2'd2;
    logic [1:0] state, last, winner, idx;
    logic [7:0] on_count, gap_count;
    logic [NZONES-1:0] elig;
    logic found, held, max_hit, release_now;
    assign elig = bus.water_req & bus.zone_en;
    assign found = |elig;
    // Search upward from last+1; descending loop lets the nearest candidate win.
    always_comb begin
        winner = last;
        idx = last;
        for (int k = NZONES; k >= 1; k--) begin
            idx = last + 2'(k);
            if (elig[idx]) winner = idx;
        end
    end
    assign held = bus.water_req[bus.grant_id] & bus.zone_en[bus.grant_id];
    assign max_hit = on_count == MAX_ON - 8'd1;
    assign release_now = !held || bus.stop || max_hit;
    assign bus.busy = state != IDLE;
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            bus.valve_en <= '0;
            bus.pump_on <= 1'b0;
            bus.timeout <= 1'b0;
            bus.grant_id <= '0;
            on_count <= 8'd0;
            gap_count <= 8'd0;
            last <= 2'd3;
        end else begin
            bus.timeout <= 1'b0;
            case (state)
                IDLE: if (!bus.stop && found) begin
                    state <= GRANT;
                    last <= winner;
                    bus.grant_id <= winner;
                    on_count <= 8'd0;
                    bus.valve_en <= {{(NZONES-1){1'b0}}, 1'b1} << winner;
                    bus.pump_on <= 1'b1;
                end
                GRANT: if (release_now) begin
                    state <= COOLDOWN;
                    bus.valve_en <= '0;
                    bus.pump_on <= 1'b0;
                    gap_count <= 8'd0;
                    bus.timeout <= max_hit && held && !bus.stop;
                end else begin
                    on_count <= on_count == 8'hFF ? on_count : on_count + 8'd1;
                end
                COOLDOWN: begin
                    state <= gap_count == GAP - 8'd1 ? IDLE : COOLDOWN;
                    gap_count <= gap_count + 8'd1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_zone_arbiter.sv
// tb_zone_arbiter: directed scenarios plus randomized traffic checked against a cycle-level behavioural model.
module tb_zone_arbiter;
    localparam int MAX_ON = 200, GAP = 4;
    logic clk = 1'b0, rst = 1'b1;
    always #5 clk = ~clk;
    zone_arbiter_if bus();
    zone_arbiter dut (.clk(clk), .rst(rst), .bus(bus));
    int tests = 0, fails = 0;
    int mg = -1, mheld = 0, moff = 0, mlast = 3, mgid = 0;
    bit mto = 1'b0;
    function automatic logic [8:0] expv();
        return {(mg >= 0) ? 4'(1 << mg) : 4'd0, (mg >= 0), 2'(mgid), (mg >= 0 || moff > 0), mto};
    endfunction
    function automatic logic [8:0] obsv();
        return {bus.valve_en, bus.pump_on, bus.grant_id, bus.busy, bus.timeout};
    endfunction
    task automatic tick();
        @(posedge clk);
        if (rst) begin
            mg = -1; moff = 0; mlast = 3; mgid = 0; mto = 1'b0;
        end else begin
            mto = 1'b0;
            if (mg >= 0) begin
                if (!(bus.water_req[mg] && bus.zone_en[mg]) || bus.stop) begin
                    mg = -1; moff = GAP;
                end else if (mheld == MAX_ON) begin
                    mg = -1; moff = GAP; mto = 1'b1;
                end else mheld++;
            end else if (moff > 0) moff--;
            else if (!bus.stop) begin
                for (int k = 1; k <= 4; k++) begin
                    int z = (mlast + k) % 4;
                    if (mg < 0 && bus.water_req[z] && bus.zone_en[z]) begin
                        mg = z; mheld = 1; mlast = z; mgid = z;
                    end
                end
            end
        end
        #1;
    endtask
    task automatic do_reset();
        rst = 1'b1; bus.water_req = '0; bus.zone_en = 4'hF; bus.stop = 1'b0;
        tick();
        rst = 1'b0;
    endtask
    task automatic test_reset();
        rst = 1'b1; bus.water_req = 4'hF; bus.zone_en = 4'hF; bus.stop = 1'b0;
        tick(); tick();
        tests++; if (obsv() !== 9'd0) begin fails++; $display("FAIL reset obs=%b exp=%b", obsv(), 9'd0); end
        rst = 1'b0; bus.water_req = '0;
    endtask
    task automatic test_basic();
        int n;
        do_reset();
        bus.water_req = 4'b1010;
        tick();
        tests++; if (bus.valve_en !== 4'b0010 || bus.grant_id !== 2'd1) begin fails++; $display("FAIL basic_grant obs=%b/%0d exp=0010/1", bus.valve_en, bus.grant_id); end
        for (int i = 0; i < 5; i++) begin
            tick();
            tests++; if (obsv() !== expv()) begin fails++; $display("FAIL basic_hold obs=%b exp=%b", obsv(), expv()); end
        end
        bus.water_req = 4'b1000;
        tick();
        tests++; if (bus.valve_en !== 4'd0 || bus.busy !== 1'b1 || bus.timeout !== 1'b0) begin fails++; $display("FAIL basic_drop obs=%b exp=%b", obsv(), 9'b000000110); end
        n = 1;
        for (int i = 0; i < 20; i++) begin
            tick();
            tests++; if (obsv() !== expv()) begin fails++; $display("FAIL basic_gap obs=%b exp=%b", obsv(), expv()); end
            if (bus.valve_en != 0) break;
            n++;
        end
        tests++; if (n !== GAP + 1 || bus.valve_en !== 4'b1000 || bus.grant_id !== 2'd3) begin fails++; $display("FAIL basic_next off=%0d valve=%b exp off=%0d valve=1000", n, bus.valve_en, GAP + 1); end
    endtask
    task automatic test_timeout();
        int hi, n;
        bit saw;
        do_reset();
        bus.water_req = 4'b0001;
        tick();
        hi = 1; saw = 1'b0;
        for (int i = 0; i < 400; i++) begin
            tick();
            if (bus.valve_en[0] == 1'b0) begin saw = bus.timeout; break; end
            hi++;
        end
        tests++; if (hi !== MAX_ON || saw !== 1'b1) begin fails++; $display("FAIL timeout_len on=%0d pulse=%0d exp on=%0d pulse=1", hi, saw, MAX_ON); end
        tick();
        tests++; if (bus.timeout !== 1'b0) begin fails++; $display("FAIL timeout_pulse obs=%b exp=0", bus.timeout); end
        n = 2;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (bus.valve_en != 0) break;
            n++;
        end
        tests++; if (n !== GAP + 1 || bus.valve_en !== 4'b0001) begin fails++; $display("FAIL timeout_regrant off=%0d valve=%b exp off=%0d valve=0001", n, bus.valve_en, GAP + 1); end
    endtask
    task automatic test_round_robin();
        int hi;
        do_reset();
        bus.water_req = 4'hF;
        tick();
        for (int g = 0; g < 5; g++) begin
            tests++; if (bus.valve_en !== 4'(1 << (g % 4))) begin fails++; $display("FAIL rr_order obs=%b exp=%b", bus.valve_en, 4'(1 << (g % 4))); end
            hi = 1;
            for (int i = 0; i < 400; i++) begin
                tick();
                if (bus.valve_en == 0) break;
                hi++;
            end
            tests++; if (hi !== MAX_ON) begin fails++; $display("FAIL rr_len obs=%0d exp=%0d", hi, MAX_ON); end
            for (int i = 0; i < 20 && bus.valve_en == 0; i++) tick();
        end
    endtask
    task automatic test_stop();
        bit bad = 1'b0;
        do_reset();
        bus.water_req = 4'b0100;
        tick();
        for (int i = 0; i < 9; i++) tick();
        bus.stop = 1'b1;
        tick();
        tests++; if (bus.valve_en !== 4'd0 || bus.timeout !== 1'b0 || bus.pump_on !== 1'b0) begin fails++; $display("FAIL stop_release obs=%b exp=%b", obsv(), 9'b000001010); end
        for (int i = 0; i < 20; i++) begin
            tick();
            if (bus.valve_en != 0) bad = 1'b1;
        end
        tests++; if (bad !== 1'b0 || bus.busy !== 1'b0) begin fails++; $display("FAIL stop_hold granted=%0d busy=%b exp granted=0 busy=0", bad, bus.busy); end
        bus.stop = 1'b0;
        tick();
        tests++; if (bus.valve_en !== 4'b0100) begin fails++; $display("FAIL stop_resume obs=%b exp=0100", bus.valve_en); end
    endtask
    task automatic test_reset_mid();
        do_reset();
        bus.water_req = 4'b0100;
        tick(); tick(); tick();
        bus.water_req = 4'b0101;
        rst = 1'b1;
        tick();
        tests++; if (obsv() !== 9'd0) begin fails++; $display("FAIL rst_mid obs=%b exp=%b", obsv(), 9'd0); end
        rst = 1'b0;
        tick();
        tests++; if (bus.valve_en !== 4'b0001 || bus.grant_id !== 2'd0) begin fails++; $display("FAIL rst_next obs=%b exp=0001", bus.valve_en); end
    endtask
    task automatic test_disabled();
        bit bad = 1'b0;
        do_reset();
        bus.zone_en = 4'b1110; bus.water_req = 4'b0001;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (bus.busy || bus.valve_en != 0) bad = 1'b1;
        end
        tests++; if (bad !== 1'b0) begin fails++; $display("FAIL disabled obs=%0d exp=0", bad); end
        bus.zone_en = 4'hF;
    endtask
    task automatic test_random();
        do_reset();
        for (int c = 0; c < 4000; c++) begin
            int b = $urandom_range(3);
            if ($urandom_range(7) == 0) bus.water_req = bus.water_req ^ (4'b1 << b);
            if ($urandom_range(63) == 0) bus.zone_en = 4'($urandom);
            if ($urandom_range(99) == 0) bus.stop = !bus.stop;
            rst = $urandom_range(499) == 0;
            tick();
            tests++; if (obsv() !== expv()) begin fails++; $display("FAIL random cyc=%0d obs=%b exp=%b", c, obsv(), expv()); end
        end
        rst = 1'b0;
    endtask
    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end
    initial begin
        bus.water_req = '0; bus.zone_en = 4'hF; bus.stop = 1'b0;
        #1;
        test_reset();
        test_basic();
        test_timeout();
        test_round_robin();
        test_stop();
        test_reset_mid();
        test_disabled();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/zone_arbiter.md
ZONE_ARBITER -- requirements
Module: zone_arbiter

Interface
REQ-001 SHALL have parameter NZONES, default 4: number of irrigation zones sharing one pump; fixed at 4 for this revision.
REQ-002 SHALL have parameter MAX_ON, default 8'd200: maximum cycles a single grant holds the pump.
REQ-003 SHALL have parameter GAP, default 8'd4: pump pressure-recovery cycles between grants; legal range 1..255.
REQ-004 SHALL have port clk, input, 1: single clock; all logic on its rising edge.
REQ-005 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-006 SHALL have port water_req, input, 4: per-zone watering request (level), bit i from zone i's water_toggle.
REQ-007 SHALL have port zone_en, input, 4: per-zone enable mask; a disabled zone is never granted.
REQ-008 SHALL have port stop, input, 1: emergency stop (e.g. rain / low reservoir), level.
REQ-009 SHALL have port valve_en, output, 4: registered one-hot (or zero) valve drive.
REQ-010 SHALL have port pump_on, output, 1: registered pump drive; equals |valve_en.
REQ-011 SHALL have port grant_id, output, 2: index of the current or last granted zone.
REQ-012 SHALL have port busy, output, 1: high in GRANT and COOLDOWN.
REQ-013 SHALL have port timeout, output, 1: one-cycle pulse when a grant is ended by MAX_ON.

Function
REQ-014 SHALL implement three states: IDLE, GRANT, COOLDOWN.
REQ-015 In IDLE with stop low, SHALL form the eligible vector elig = water_req & zone_en; if nonzero, SHALL select the first set bit searching upward from (last+1) mod 4 with wrap, and SHALL enter GRANT.
REQ-016 Grant latency SHALL be one cycle: an eligible request sampled in IDLE at edge N produces valve_en/pump_on high after edge N.
REQ-017 On entering GRANT, SHALL load last and grant_id with the winner, clear on_count to 0, and drive valve_en = 1<<winner.
REQ-018 In GRANT, SHALL increment the 8-bit on_count each cycle; the count SHALL never wrap.
REQ-019 In GRANT, SHALL release when the granted zone's water_req or zone_en is low, stop is high, or on_count == MAX_ON-1; releases SHALL take effect at the next edge, with valve_en = 0 and entry to COOLDOWN.
REQ-020 A MAX_ON release SHALL hold valve_en high for exactly MAX_ON cycles and SHALL pulse timeout for one cycle, coincident with valve_en falling.
REQ-021 A timeout SHALL NOT be flagged when a request drop or stop coincides with on_count == MAX_ON-1; request drop and stop SHALL take priority.
REQ-022 In COOLDOWN, SHALL hold all valves and the pump off for exactly GAP cycles, using gap_count loaded with 0 and compared against GAP-1, then return to IDLE.
REQ-023 Minimum valve-off time between consecutive grants SHALL therefore be GAP+1 cycles.
REQ-024 With stop high, SHALL NOT grant in IDLE, and COOLDOWN SHALL still complete normally.
REQ-025 Requests arriving during GRANT or COOLDOWN SHALL NOT be latched; arbitration SHALL use only water_req as sampled in IDLE.
REQ-026 grant_id SHALL hold its value through COOLDOWN and IDLE until the next grant.
REQ-027 A zone that timed out and is still requesting SHALL be served again only after all other eligible zones get their round-robin turn.

Reset
REQ-028 With rst high at an edge, SHALL force state=IDLE, valve_en=0, pump_on=0, busy=0, timeout=0, grant_id=0, on_count=0, gap_count=0, and last=3, so zone 0 has first priority.
REQ-029 Reset asserted mid-GRANT SHALL close the valve and stop the pump at that same edge, with no COOLDOWN.
REQ-030 Outputs SHALL have defined values from the first clock edge with rst high; no initial blocks shall be relied on.

Verification
REQ-031 Reset, water_req=4'b1010, zone_en=4'hF -> grant zone 1 one cycle after IDLE; release at req drop; GAP=4 off cycles; then zone 3 granted.
REQ-032 water_req=4'b0001 held, MAX_ON=200 -> valve_en[0] high for exactly 200 cycles, then a timeout pulse, 4 off cycles, and regrant of zone 0.
REQ-033 All four zones requesting continuously -> grant order 0,1,2,3,0, each for MAX_ON cycles.
REQ-034 stop asserted at grant cycle 10 -> valve off at the next edge with no timeout; no grant occurs while stop is high; grant resumes one cycle after stop falls in IDLE.
REQ-035 rst pulsed mid-GRANT of zone 2 -> all outputs zero at that edge; next grant goes to zone 0 when zones 0 and 2 both request.
REQ-036 zone_en=4'b1110 with water_req=4'b0001 -> no grant and busy stays low.
